gcd: RTL and testbench
======================

Name: gcd

Overview:
- Sequential greatest-common-divisor engine for unsigned operands. It uses the iterative subtract-the-smaller (Euclid subtraction) method.
- A one-cycle start pulse launches a computation. A one-cycle done pulse returns the result.
- Standalone arithmetic helper, driven by a controller or bench that polls done.

Parameters:
- WIDTH, 4, operand and result width in bits.
- MSB, WIDTH-1, derived top bit index; not overridden by users.

Ports:
- clk    in   1      rising-edge clock
- rst    in   1      synchronous reset, active-high
- start  in   1      launch request; sampled only when idle
- a      in   WIDTH  operand A, captured when start is accepted
- b      in   WIDTH  operand B, captured when start is accepted
- out    out  WIDTH  GCD result; valid when done=1 and held until the next accepted start
- done   out  1      one-cycle completion pulse
- busy   out  1      high while a computation is in progress

Behaviour:
- Interface: one clock, clk; reset is rst, synchronous and active-high.
- Reset state: all outputs 0 (out=0, done=0, busy=0), state=IDLE, internal registers X and Y cleared. Reset overrides everything, including mid-computation; the in-flight result is discarded and no done is issued.
- States: IDLE and CALC.
- IDLE:
  - start=1 at a clock edge: X<=a, Y<=b, busy<=1, done<=0, go to CALC.
  - start=0: stay in IDLE, done<=0.
- CALC, evaluated every edge in this priority order:
  - X==0: result=Y.
  - else Y==0: result=X.
  - else X==Y: result=X.
  - else X>Y: X<=X-Y, stay in CALC.
  - else: Y<=Y-X, stay in CALC.
  - On any result: out<=result, done<=1 for exactly one cycle, busy<=0, go to IDLE.
- start asserted during CALC is ignored; the operands are not re-captured.
- start asserted in the same cycle that done=1 is accepted (back-to-back operation).
- Latency: done rises on the (k+2)th edge after the edge that accepts start, where k is the number of subtract steps.
  - Example: 12,6 gives k=1, so done rises on edge 3.
  - Worst case for WIDTH=4 is a=15, b=1: k=14, done on edge 16.
- Special values: gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0.
- Arithmetic: unsigned WIDTH-bit; subtraction never underflows because the smaller operand is always subtracted from the larger.
- out is unchanged from done until the next accepted result; it is not cleared on start.

Optional Feature:
- Macro: GCD_EARLY_EXIT_EN.
- Defined: CALC additionally terminates when X==1 or Y==1, with result 1. This check has priority below the zero checks and above the equality check. Example: 15,1 completes with done on edge 2.
- Undefined: pure subtraction behaviour as specified above.
- Results are identical either way; only latency differs.

Decomposition:
- gcd_pkg holds:
  - state enum gcd_state_e {IDLE, CALC};
  - a localparam for the state encoding width.
- One sub-module is natural: gcd_datapath. It holds the X/Y registers, comparator, subtractor and result mux, and exposes x_eq_y, x_gt_y, x_zero, y_zero (and x_one, y_one under GCD_EARLY_EXIT_EN).
- The top-level gcd holds the FSM, done/busy/out registers and the start handshake.

Test Plan:
- Reset 2 cycles, then a=12, b=6, start 1 cycle -> done pulse within 100 cycles, out=6; busy high during CALC, low when done=1.
- a=15, b=5 immediately after the first done -> out=5, done exactly one cycle wide.
- a=0, b=7 -> out=7; a=9, b=0 -> out=9; a=0, b=0 -> out=0, each with done on edge 2.
- a=15, b=1 -> out=1, done on edge 16 (edge 2 with GCD_EARLY_EXIT_EN); a=14, b=10 -> out=2.
- start a=15, b=1, then pulse start with a=12, b=6 while busy -> ignored, result out=1.
- Assert rst mid-CALC -> next edge busy=0, done=0, out=0, no done afterwards; a fresh start then computes correctly.

Source files
------------

// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD engine.
//   STATE_W     : width of the controller state encoding
//   gcd_state_e : controller states (IDLE waiting for start, CALC iterating)
// Optional build macro used by the engine: GCD_EARLY_EXIT_EN (see gcd.sv).
// ---------------------------------------------------------------------------
package gcd_pkg;

    localparam int STATE_W = 1;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_datapath.sv
// ---------------------------------------------------------------------------
// gcd_datapath
// Operand registers X/Y, comparator, subtractor and result selection for the
// subtract-the-smaller GCD engine. The controller decides when to load or
// subtract; this block only reports the relations between X and Y.
//
// Build macro: GCD_EARLY_EXIT_EN adds x_one/y_one flags and a forced
//              result of 1 when either operand reaches 1.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset, clears X and Y
//   load    in   capture a -> X, b -> Y
//   sub_x   in   X <= X - Y (controller guarantees X > Y)
//   sub_y   in   Y <= Y - X (controller guarantees Y > X)
//   a, b    in   operands
//   x_eq_y  out  X == Y
//   x_gt_y  out  X >  Y
//   x_zero  out  X == 0
//   y_zero  out  Y == 0
//   x_one   out  X == 1 (GCD_EARLY_EXIT_EN only)
//   y_one   out  Y == 1 (GCD_EARLY_EXIT_EN only)
//   result  out  terminal value selected by the same priority as the FSM
// ---------------------------------------------------------------------------
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             sub_x,
    input  logic             sub_y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             x_eq_y,
    output logic             x_gt_y,
    output logic             x_zero,
    output logic             y_zero,
`ifdef GCD_EARLY_EXIT_EN
    output logic             x_one,
    output logic             y_one,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int MSB = WIDTH - 1;
    localparam logic [MSB:0] ZERO = '0;
    localparam logic [MSB:0] ONE  = {{MSB{1'b0}}, 1'b1};

    logic [MSB:0] x_reg, x_next;
    logic [MSB:0] y_reg, y_next;
    logic [MSB:0] diff_xy;
    logic [MSB:0] diff_yx;

    // Both differences are formed; only the one whose minuend is larger is
    // ever selected, so neither selected path can wrap.
    assign diff_xy = x_reg - y_reg;
    assign diff_yx = y_reg - x_reg;

    assign x_eq_y = (x_reg == y_reg);
    assign x_gt_y = (x_reg >  y_reg);
    assign x_zero = (x_reg == ZERO);
    assign y_zero = (y_reg == ZERO);
`ifdef GCD_EARLY_EXIT_EN
    assign x_one  = (x_reg == ONE);
    assign y_one  = (y_reg == ONE);
`endif

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (load) begin
            x_next = a;
            y_next = b;
        end else if (sub_x) begin
            x_next = diff_xy;
        end else if (sub_y) begin
            y_next = diff_yx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg <= ZERO;
            y_reg <= ZERO;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    // Terminal value: zero operands yield the other operand; a unit operand
    // (early-exit build) yields 1; otherwise X (equal operands).
    always_comb begin
        result = x_reg;
        if (x_zero) begin
            result = y_reg;
        end else if (y_zero) begin
            result = x_reg;
`ifdef GCD_EARLY_EXIT_EN
        end else if (x_one || y_one) begin
            result = ONE;
`endif
        end
    end

endmodule : gcd_datapath

// File: rtl/gcd.sv
// ---------------------------------------------------------------------------
// gcd
// Sequential greatest-common-divisor engine for unsigned operands using the
// iterative subtract-the-smaller method. A one-cycle start pulse launches a
// computation while idle; a one-cycle done pulse returns the result on out,
// which is held until the next completion.
//
// Build macro: GCD_EARLY_EXIT_EN -- also finish as soon as X or Y equals 1
//              (result 1). Results are identical; only latency shrinks.
//
// Parameters:
//   WIDTH  operand/result width in bits
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   launch request, sampled only when idle
//   a, b   in   operands, captured when start is accepted
//   out    out  GCD result, valid with done and held until the next result
//   done   out  one-cycle completion pulse
//   busy   out  high while a computation is in progress
// ---------------------------------------------------------------------------
module gcd
    import gcd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    gcd_state_e   state_reg, state_next;
    logic [MSB:0] out_reg, out_next;
    logic         done_reg, done_next;
    logic         busy_reg, busy_next;

    logic         load;
    logic         sub_x;
    logic         sub_y;
    logic         finish;
    logic         x_eq_y;
    logic         x_gt_y;
    logic         x_zero;
    logic         y_zero;
    logic [MSB:0] result;
`ifdef GCD_EARLY_EXIT_EN
    logic         x_one;
    logic         y_one;
`endif

    gcd_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .sub_x  (sub_x),
        .sub_y  (sub_y),
        .a      (a),
        .b      (b),
        .x_eq_y (x_eq_y),
        .x_gt_y (x_gt_y),
        .x_zero (x_zero),
        .y_zero (y_zero),
`ifdef GCD_EARLY_EXIT_EN
        .x_one  (x_one),
        .y_one  (y_one),
`endif
        .result (result)
    );

    // Any terminating condition; the datapath's result mux applies the
    // priority among them.
`ifdef GCD_EARLY_EXIT_EN
    assign finish = x_zero || y_zero || x_one || y_one || x_eq_y;
`else
    assign finish = x_zero || y_zero || x_eq_y;
`endif

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        done_next  = 1'b0;
        busy_next  = busy_reg;
        load       = 1'b0;
        sub_x      = 1'b0;
        sub_y      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // done is low again here even when start arrives in the
                // same cycle as the previous done pulse (back-to-back).
                if (start) begin
                    load       = 1'b1;
                    busy_next  = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                // start is deliberately ignored here.
                if (finish) begin
                    out_next   = result;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else if (x_gt_y) begin
                    sub_x = 1'b1;
                end else begin
                    sub_y = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            out_reg   <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
        end
    end

    assign out  = out_reg;
    assign done = done_reg;
    assign busy = busy_reg;

endmodule : gcd

// File: tb/tb_gcd.sv
// ---------------------------------------------------------------------------
// tb_gcd
// Self-checking bench for gcd. Expected results come from a reference model
// using Euclid's division algorithm; expected latency comes from the sum of
// division quotients (each quotient is a run of subtract steps).
// Edge numbering: the edge that accepts start is edge 1; done for k subtract
// steps is expected on edge k+2, i.e. k+1 edges after the accepting edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gcd;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         done;
    logic         busy;

    int n_checks = 0;
    int n_fails  = 0;

    gcd #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .out   (out),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int model_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Number of subtract steps. Dividing x by y with quotient q takes q
    // subtractions, except the final exact division which stops at equality
    // after q-1. With early exit, a remainder of 1 ends the run at once.
    function automatic int model_steps(input int x, input int y);
        int s;
        int q;
        int r;
        int t;
        s = 0;
        if (x == 0 || y == 0) return 0;
`ifdef GCD_EARLY_EXIT_EN
        if (x == 1 || y == 1) return 0;
`endif
        if (x < y) begin
            t = x; x = y; y = t;
        end
        forever begin
            q = x / y;
            r = x % y;
            if (r == 0) return s + q - 1;
            s = s + q;
`ifdef GCD_EARLY_EXIT_EN
            if (r == 1) return s;
`endif
            x = y;
            y = r;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present operands with start for one edge (the accepting edge, edge 1).
    task automatic launch(input int ta, input int tb);
        start = 1'b1;
        a     = W'(ta);
        b     = W'(tb);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("done_after_start", int'(done), 0);
    endtask

    // Wait (bounded) for done; 'elapsed' edges since edge 1 already consumed.
    task automatic wait_result(input int ta, input int tb, input int elapsed);
        int cycles;
        int exp_out;
        int exp_k;
        cycles  = elapsed;
        exp_out = model_gcd(ta, tb);
        exp_k   = model_steps(ta, tb);
        while (done !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done !== 1'b1) check("busy_during_calc", int'(busy), 1);
        end
        check("done_seen", int'(done), 1);
        check("result", int'(out), exp_out);
        check("latency", cycles, exp_k + 1);
        check("busy_at_done", int'(busy), 0);
        $display("op a=%0d b=%0d -> out=%0d expected=%0d edges_after_accept=%0d k=%0d",
                 ta, tb, out, exp_out, cycles, exp_k);
    endtask

    // One idle edge after a result: done must drop, out must hold.
    task automatic idle_after(input int ta, input int tb);
        @(posedge clk);
        #1;
        check("done_one_cycle", int'(done), 0);
        check("out_hold", int'(out), model_gcd(ta, tb));
    endtask

    initial begin
        int ra;
        int rb;
        int pa;
        int pb;
        bit seen_done;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", int'(out), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 12,6 then 15,5 back-to-back (start while done is high).
        launch(12, 6);
        wait_result(12, 6, 0);
        launch(15, 5);          // second check in launch confirms done width
        wait_result(15, 5, 0);
        idle_after(15, 5);

        // Special values and worst case.
        launch(0, 7);  wait_result(0, 7, 0);  idle_after(0, 7);
        launch(9, 0);  wait_result(9, 0, 0);  idle_after(9, 0);
        launch(0, 0);  wait_result(0, 0, 0);  idle_after(0, 0);
        launch(15, 1); wait_result(15, 1, 0); idle_after(15, 1);
        launch(14, 10); wait_result(14, 10, 0); idle_after(14, 10);

        // start during CALC must be ignored.
        launch(15, 1);
        start = 1'b1;
        a     = W'(12);
        b     = W'(6);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result(15, 1, 1);
        idle_after(15, 1);
        @(posedge clk);
        #1;
        check("no_recapture_busy", int'(busy), 0);

        // Reset mid-computation (14,10 needs 4 steps in either build).
        launch(14, 10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_out", int'(out), 0);
        seen_done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("midrst_no_done", int'(seen_done), 0);
        $display("reset mid-calc: busy=%0d done=%0d out=%0d later_done=%0d",
                 busy, done, out, seen_done);
        launch(12, 8);
        wait_result(12, 8, 0);
        idle_after(12, 8);

        // Random operands, randomly back-to-back.
        pa = 12;
        pb = 8;
        for (int i = 0; i < 24; i++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) idle_after(pa, pb);
            launch(ra, rb);
            wait_result(ra, rb, 0);
            pa = ra;
            pb = rb;
        end
        idle_after(pa, pb);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_gcd
